// File: rtl/apb_i2c_bridge.sv
// APB3 completer that forwards each APB transfer as one request on the APB-I2C bus,
// holding the APB access phase in wait states until the I2C master completes or times out.
module apb_i2c_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              i2c_ce,
  output logic              i2c_wren,
  output logic              i2c_rden,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [DATA_W-1:0] i2c_wdata,
  input  logic [DATA_W-1:0] i2c_rdata,
  input  logic              i2c_ready,
  input  logic              i2c_error
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              timeout_hit;
  logic              write_q;
  logic              abandon_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic              ce_q;
  logic              wren_q;
  logic              rden_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Saturating increment; the abort fires on the cycle the count would reach TIMEOUT,
  // so ISSUE/BUSY each last at most TIMEOUT cycles.
  always_comb begin
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      abandon_q <= 1'b0;
      err_q     <= 1'b0;
      rd_buf_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      ce_q      <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values;
      // the response defaults below make pready a single-cycle pulse with zeroed data otherwise.
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            addr_q    <= paddr;
            wdata_q   <= pwdata;
            write_q   <= pwrite;
            ce_q      <= 1'b1;
            wren_q    <= pwrite;
            rden_q    <= !pwrite;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_buf_q  <= '0;
            abandon_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!psel) abandon_q <= 1'b1;
          // Drop ce as soon as the master accepts so it cannot start a second transfer.
          if (!i2c_ready) begin
            ce_q    <= 1'b0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end else if (timeout_hit) begin
            ce_q    <= 1'b0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            err_q   <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BUSY: begin
          if (!psel) abandon_q <= 1'b1;
          if (i2c_ready) begin
            rd_buf_q <= write_q ? '0 : i2c_rdata;
            err_q    <= i2c_error;
            state_q  <= DONE;
          end else if (timeout_hit) begin
            rd_buf_q <= '0;
            err_q    <= 1'b1;
            cnt_q    <= cnt_d;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // A requester that walked away gets no response; the result is simply dropped.
          if (abandon_q || !psel) begin
            state_q <= IDLE;
          end else if (penable) begin
            pready_q  <= 1'b1;
            prdata_q  <= write_q ? '0 : rd_buf_q;
            pslverr_q <= err_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign i2c_ce    = ce_q;
  assign i2c_wren  = wren_q;
  assign i2c_rden  = rden_q;
  assign i2c_addr  = addr_q;
  assign i2c_wdata = wdata_q;

endmodule

// File: doc/apb_i2c_bridge.md
Name: apb_i2c_bridge

Overview:
APB3 completer that turns one APB transfer into one transfer on the APB-I2C bus (ce, wren, rden, wdata, addr, rdata, ready, error). It sits directly upstream of the I2C block.
- Holds the APB transfer in wait states (pready low) until the I2C master reports completion.
- Returns read data and the I2C error status to the APB requester.
- Bounds every transfer with a timeout.

Parameters:
- ADDR_W, 8: APB / I2C address width; bits [7:6] are the device id, bits [5:0] the memory address. Passed through unchanged.
- DATA_W, 8: data width.
- TIMEOUT, 4096: maximum clk cycles spent in ISSUE and in BUSY, each counted separately, before the transfer is aborted with error.

Ports:
- clk  in  1  system clock (same clock as the I2C block).
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error response.
- i2c_ce  out  1  request strobe to the I2C block.
- i2c_wren  out  1  write request.
- i2c_rden  out  1  read request.
- i2c_addr  out  ADDR_W  registered copy of paddr.
- i2c_wdata  out  DATA_W  registered copy of pwdata.
- i2c_rdata  in  DATA_W  read data from the I2C block.
- i2c_ready  in  1  1 = I2C master idle or transfer complete; 0 = transfer in progress.
- i2c_error  in  1  slave NACK / transfer error; sampled at completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-transfer drops i2c_ce, i2c_wren and i2c_rden immediately; no APB response is given.
- States: IDLE -> ISSUE -> BUSY -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - On psel=1 and penable=0 (APB setup), capture paddr, pwdata and pwrite.
  - Next cycle: i2c_ce=1, i2c_wren=pwrite, i2c_rden=~pwrite, i2c_addr and i2c_wdata valid. Go to ISSUE and clear the counter.
- ISSUE:
  - Hold the request until i2c_ready=0 is sampled (transfer accepted).
  - On that edge: i2c_ce, i2c_wren and i2c_rden go to 0, counter clears, go to BUSY. Dropping ce here stops the I2C master from starting a second transfer.
  - If the counter reaches TIMEOUT: drop the request, set err=1, go to DONE.
- BUSY:
  - Wait for i2c_ready=1.
  - On that edge: latch rd_buf=i2c_rdata (reads only) and err=i2c_error, then go to DONE.
  - If the counter reaches TIMEOUT: err=1, rd_buf=0, go to DONE.
- DONE:
  - If psel=1 and penable=1: pready=1 for exactly one cycle; prdata = rd_buf for reads, 0 for writes; pslverr = err. Then return to IDLE.
  - prdata and pslverr are 0 whenever pready=0.
- pready is 0 in IDLE, ISSUE and BUSY; the access phase is extended by wait states.
- APB protocol violations:
  - psel drops before DONE: the I2C transfer still completes (or times out), the result is discarded, and the block returns to IDLE without pready.
  - A new setup phase is not sampled until the block is back in IDLE.
- Timeout counter: width clog2(TIMEOUT+1); saturates; increments only in ISSUE and BUSY.
- Minimum latency: setup-to-pready = 4 clk cycles plus the I2C transfer time.
- i2c_addr and i2c_wdata stay stable from ISSUE until the next capture.

Test Plan:
1. APB write paddr=0x41, pwdata=0x5F; I2C model drops i2c_ready 3 cycles after ce and raises it 30 cycles later -> i2c_ce/i2c_wren high only in ISSUE, i2c_addr=0x41, i2c_wdata=0x5F; one-cycle pready with pslverr=0, prdata=0.
2. APB read paddr=0x41 after test 1; model returns i2c_rdata=0x5F -> i2c_rden high in ISSUE only; pready with prdata=0x5F, pslverr=0.
3. Read with i2c_error=1 at completion (wrong device id, paddr=0xC1) -> pready=1, pslverr=1, prdata holds the sampled i2c_rdata.
4. TIMEOUT=16, i2c_ready held at 1 (never accepts) -> ce dropped after 16 cycles in ISSUE; pready with pslverr=1, prdata=0. Repeat with i2c_ready stuck at 0 in BUSY -> same response.
5. Back-to-back write(0x02, 0xAA) then read(0x02) -> second setup is sampled only after DONE; read returns 0xAA; no overlapping i2c_ce pulses.
6. reset driven to 0 during BUSY -> all outputs 0 asynchronously; after release a new read completes normally with correct data.
